// File: rtl/accum_calib_buffer_if.sv
// Bundles the accumulator beat stream, the calibration handshake and the drained
// quantizer stream of accum_calib_buffer.
interface accum_calib_buffer_if #(
    parameter int DEPTH = 64
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_last;
    logic              in_ready;
    logic              start_calib;
    logic [31:0]       max_abs;
    logic              calib_busy;
    logic              calib_ready;
    logic [31:0]       q_data;
    logic              q_valid;
    logic              q_last;
    logic              done;
    logic              trunc;
    logic [ADDR_W:0]   vec_len;

    modport master (
        output in_valid, in_data, in_last, calib_busy, calib_ready,
        input  in_ready, start_calib, max_abs, q_data, q_valid, q_last, done, trunc, vec_len
    );

    modport slave (
        input  in_valid, in_data, in_last, calib_busy, calib_ready,
        output in_ready, start_calib, max_abs, q_data, q_valid, q_last, done, trunc, vec_len
    );
endinterface

// File: rtl/accum_calib_buffer.sv
// Buffers one vector of int32 accumulator values, tracks max |value| for the
// quantization stage, requests calibration, then replays the vector in order.
module accum_calib_buffer #(
    parameter int DEPTH = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    accum_calib_buffer_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        CALIB = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   vec_len_q, vec_len_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]       max_abs_q, max_abs_d;
    logic [31:0]       q_data_q, q_data_d;
    logic              q_valid_q, q_valid_d;
    logic              q_last_q, q_last_d;
    logic              done_q, done_d;
    logic              trunc_q, trunc_d;
    logic [31:0]       mem_q [DEPTH];

    logic              accept_s;
    logic              wr_en_s;
    logic              last_rd_s;
    logic [31:0]       abs_s;

    // Two's-complement magnitude; -2^31 maps to 0x80000000 as an unsigned value.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (~v + 32'd1) : v;
    endfunction

    // Next-state and next-output computation for the fill/calibrate/drain sequence.
    always_comb begin
        state_d   = state_q;
        vec_len_d = vec_len_q;
        rd_ptr_d  = rd_ptr_q;
        max_abs_d = max_abs_q;
        q_data_d  = q_data_q;
        q_valid_d = 1'b0;
        q_last_d  = 1'b0;
        done_d    = 1'b0;
        trunc_d   = 1'b0;
        wr_en_s   = 1'b0;
        accept_s  = bus.in_valid && (state_q == FILL);
        abs_s     = abs32(bus.in_data);
        last_rd_s = ({1'b0, rd_ptr_q} == (vec_len_q - LEN_ONE));

        case (state_q)
            FILL: begin
                if (accept_s) begin
                    wr_en_s   = 1'b1;
                    vec_len_d = vec_len_q + LEN_ONE;
                    max_abs_d = (abs_s > max_abs_q) ? abs_s : max_abs_q;
                    if (bus.in_last || (vec_len_q == LEN_FULL)) begin
                        state_d = CALIB;
                        trunc_d = !bus.in_last;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            CALIB: begin
                // The request is taken in the cycle the stage is not busy.
                if (!bus.calib_busy) begin
                    state_d = WAIT;
                end else begin
                    state_d = CALIB;
                end
            end
            WAIT: begin
                if (bus.calib_ready) begin
                    state_d  = DRAIN;
                    rd_ptr_d = '0;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                // One idle cycle after the final entry closes the vector and pulses done.
                if (q_last_q) begin
                    state_d   = FILL;
                    done_d    = 1'b1;
                    vec_len_d = '0;
                    max_abs_d = 32'd0;
                    rd_ptr_d  = '0;
                end else begin
                    q_valid_d = 1'b1;
                    q_data_d  = mem_q[rd_ptr_q];
                    q_last_d  = last_rd_s;
                    rd_ptr_d  = rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FILL;
            vec_len_q <= '0;
            rd_ptr_q  <= '0;
            max_abs_q <= 32'd0;
            q_data_q  <= 32'd0;
            q_valid_q <= 1'b0;
            q_last_q  <= 1'b0;
            done_q    <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_len_q <= vec_len_d;
            rd_ptr_q  <= rd_ptr_d;
            max_abs_q <= max_abs_d;
            q_data_q  <= q_data_d;
            q_valid_q <= q_valid_d;
            q_last_q  <= q_last_d;
            done_q    <= done_d;
            trunc_q   <= trunc_d;
        end
    end

    // Vector storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[vec_len_q[ADDR_W-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready    = (state_q == FILL);
    assign bus.start_calib = (state_q == CALIB);
    assign bus.max_abs     = max_abs_q;
    assign bus.q_data      = q_data_q;
    assign bus.q_valid     = q_valid_q;
    assign bus.q_last      = q_last_q;
    assign bus.done        = done_q;
    assign bus.trunc       = trunc_q;
    assign bus.vec_len     = vec_len_q;
endmodule

// File: tb/tb_accum_calib_buffer.sv
// Randomized scoreboard bench for accum_calib_buffer with a behavioural vector
// model and an emulated quantization stage.
module tb_accum_calib_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] data;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    accum_calib_buffer_if #(.DEPTH(DEPTH)) bus();

    accum_calib_buffer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          busy_cfg = 0;
    int          ready_cfg = 1;
    int          exp_start_len = 1;
    logic [31:0] stim [0:7];
    int          vk;
    longint      vmax;
    bit          vtrunc;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Quantization stage: busy for busy_cfg cycles per request, scale valid ready_cfg cycles after acceptance.
    initial begin
        int busy_cnt;
        int rdy_cnt;
        busy_cnt = 0;
        rdy_cnt = 0;
        bus.calib_busy = 1'b0;
        bus.calib_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bus.calib_busy = 1'b0;
                bus.calib_ready = 1'b0;
                rdy_cnt = 0;
                busy_cnt = busy_cfg;
            end else begin
                if (rdy_cnt > 0) begin
                    rdy_cnt--;
                    if (rdy_cnt == 0) bus.calib_ready = 1'b1;
                end
                if (!bus.start_calib) begin
                    busy_cnt = busy_cfg;
                    bus.calib_busy = 1'b0;
                end else if (busy_cnt > 0) begin
                    bus.calib_busy = 1'b1;
                    busy_cnt--;
                end else begin
                    bus.calib_busy = 1'b0;
                    bus.calib_ready = 1'b0;
                    rdy_cnt = ready_cfg;
                end
            end
        end
    end

    // Monitor: pops expected entries on q_valid, checks gaps, done timing and request length.
    initial begin
        bit   drain_active;
        bit   prev_qlast;
        int   start_run;
        exp_t e;
        drain_active = 1'b0;
        prev_qlast = 1'b0;
        start_run = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                drain_active = 1'b0;
                prev_qlast = 1'b0;
                start_run = 0;
            end else begin
                if (bus.q_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_q_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("q_data", bus.q_data, e.data);
                        check("q_last", bus.q_last, e.last);
                    end
                    drain_active = !bus.q_last;
                end else if (drain_active) begin
                    check("q_valid_gap", 0, 1);
                    drain_active = 1'b0;
                end
                if (prev_qlast || bus.done) check("done_after_q_last", bus.done, prev_qlast);
                prev_qlast = bus.q_valid && bus.q_last;
                if (bus.start_calib) begin
                    start_run++;
                end else if (start_run > 0) begin
                    check("start_calib_len", start_run, exp_start_len);
                    start_run = 0;
                end
            end
        end
    end

    task automatic check_close();
        check("close_vec_len", bus.vec_len, vk);
        check("close_max_abs", bus.max_abs, vmax);
        check("close_trunc", bus.trunc, vtrunc);
        check("close_in_ready", bus.in_ready, 0);
        check("close_start_calib", bus.start_calib, 1);
    endtask

    // Drives n beats of stim[]; the model accepts beats until in_last or a full buffer.
    task automatic drive_beats(input int n, input bit use_last, input int busy_v, input int ready_v);
        bit     closed;
        int     close_idx;
        longint v;
        longint a;
        exp_t   e;
        busy_cfg = busy_v;
        ready_cfg = ready_v;
        exp_start_len = busy_v + 1;
        vk = 0;
        vmax = 0;
        vtrunc = 1'b0;
        closed = 1'b0;
        close_idx = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0 && close_idx == i - 1) check_close();
            check("in_ready_beat", bus.in_ready, !closed);
            bus.in_valid = 1'b1;
            bus.in_data = stim[i];
            bus.in_last = use_last && (i == n - 1);
            if (!closed) begin
                vk++;
                v = longint'($signed(stim[i]));
                a = (v < 0) ? -v : v;
                if (a > vmax) vmax = a;
                if (bus.in_last || vk == DEPTH) begin
                    closed = 1'b1;
                    close_idx = i;
                    vtrunc = !bus.in_last;
                end
                e.data = stim[i];
                e.last = closed;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        if (close_idx == n - 1) check_close();
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            check("hold_max_abs", bus.max_abs, vmax);
            check("hold_vec_len", bus.vec_len, vk);
            check("busy_in_ready", bus.in_ready, 0);
            check("trunc_pulse", bus.trunc, 0);
        end
        check("done_seen", got, 1);
        if (got) begin
            check("done_max_abs", bus.max_abs, 0);
            check("done_vec_len", bus.vec_len, 0);
            check("done_in_ready", bus.in_ready, 1);
            check("done_all_drained", exp_q.size(), 0);
        end
    endtask

    task automatic run_vector(input int n, input bit use_last, input int busy_v, input int ready_v);
        drive_beats(n, use_last, busy_v, ready_v);
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_start_calib"}, bus.start_calib, 0);
        check({tag, "_max_abs"}, bus.max_abs, 0);
        check({tag, "_q_data"}, bus.q_data, 0);
        check({tag, "_q_valid"}, bus.q_valid, 0);
        check({tag, "_q_last"}, bus.q_last, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_trunc"}, bus.trunc, 0);
        check({tag, "_vec_len"}, bus.vec_len, 0);
    endtask

    initial begin
        int  n;
        bit  ul;
        bit  seen;
        bus.in_valid = 1'b0;
        bus.in_data = 32'd0;
        bus.in_last = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        stim[0] = 32'd5; stim[1] = -32'sd300; stim[2] = 32'd7; stim[3] = -32'sd2;
        run_vector(4, 1'b1, 0, 3);

        stim[0] = 32'h8000_0000; stim[1] = 32'd1;
        run_vector(2, 1'b1, 0, 2);

        stim[0] = 32'd1; stim[1] = 32'd2; stim[2] = 32'd3; stim[3] = 32'd4; stim[4] = 32'd5;
        run_vector(5, 1'b0, 0, 1);

        stim[0] = 32'd77; stim[1] = -32'sd78;
        run_vector(2, 1'b1, 5, 2);

        stim[0] = -32'sd9;
        run_vector(1, 1'b1, 0, 1);
        stim[0] = 32'd4; stim[1] = 32'd2;
        run_vector(2, 1'b1, 0, 1);

        // Reset while the second entry is on q_data.
        stim[0] = 32'd11; stim[1] = 32'd22; stim[2] = 32'd33;
        drive_beats(3, 1'b1, 0, 1);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (bus.q_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("first_drain_seen", seen, 1);
        @(posedge clk); #1;
        check("second_entry_valid", bus.q_valid, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_abort_q_valid", bus.q_valid, 0);
        end

        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 6);
            ul = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0: stim[i] = 32'h8000_0000;
                    1: stim[i] = 32'($signed($urandom_range(0, 200)) - 100);
                    default: stim[i] = $urandom;
                endcase
            end
            run_vector(n, ul, $urandom_range(0, 3), $urandom_range(1, 4));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
